// File: rtl/mem_access_ctrl_if.sv
// Request/memory handshake bundle between the control unit and
// the load/store sequencer.
interface mem_access_ctrl_if;
   logic       req;
   logic       req_store;
   logic [1:0] req_size;
   logic       req_signed;
   logic [1:0] addr_lsb;
   logic       MFC;
   logic       MAR_Enable;
   logic       MDR_Enable;
   logic       MDR_Mux_select;
   logic       TEMP_Enable;
   logic       RAM_enable;
   logic [5:0] RAM_OpCode;
   logic       busy;
   logic       done;
   logic       trap;
   logic [2:0] trap_tt;

   modport master (
      output req, req_store, req_size, req_signed, addr_lsb, MFC,
      input  MAR_Enable, MDR_Enable, MDR_Mux_select, TEMP_Enable,
      input  RAM_enable, RAM_OpCode, busy, done, trap, trap_tt
   );

   modport slave (
      input  req, req_store, req_size, req_signed, addr_lsb, MFC,
      output MAR_Enable, MDR_Enable, MDR_Mux_select, TEMP_Enable,
      output RAM_enable, RAM_OpCode, busy, done, trap, trap_tt
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: MAR load, store-data capture, RAM/MFC
// handshake, load capture, alignment and bus-timeout traps.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Clr,
   mem_access_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_ACCESS,
      S_CAPTURE,
      S_DONE,
      S_TRAP
   } state_e;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic       store_q, store_d;
   logic [1:0] size_q, size_d;
   logic       sgn_q, sgn_d;
   logic [1:0] lsb_q, lsb_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] tt_q, tt_d;
   logic       misaligned;
   logic [5:0] opcode;

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= S_IDLE;
         store_q <= 1'b0;
         size_q  <= 2'b00;
         sgn_q   <= 1'b0;
         lsb_q   <= 2'b00;
         cnt_q   <= 8'd0;
         tt_q    <= 3'b000;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         lsb_q   <= lsb_d;
         cnt_q   <= cnt_d;
         tt_q    <= tt_d;
      end
   end

   assign misaligned = ((size_q == 2'b01) && lsb_q[0]) ||
                       ((size_q == 2'b10) && (lsb_q != 2'b00));

   always_comb begin
      state_d = state_q;
      store_d = store_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      lsb_d   = lsb_q;
      cnt_d   = cnt_q;
      tt_d    = tt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               store_d = bus.req_store;
               size_d  = bus.req_size;
               sgn_d   = bus.req_signed;
               lsb_d   = bus.addr_lsb;
               tt_d    = 3'b000;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (size_q == 2'b11) begin
               tt_d    = 3'b011;
               state_d = S_TRAP;
            end else if (misaligned) begin
               tt_d    = 3'b001;
               state_d = S_TRAP;
            end else if (store_q) begin
               state_d = S_WDATA;
            end else begin
               cnt_d   = 8'd0;
               state_d = S_ACCESS;
            end
         end
         S_WDATA: begin
            cnt_d   = 8'd0;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            // MFC takes priority over an expiring wait count
            if (bus.MFC) begin
               state_d = store_q ? S_DONE : S_CAPTURE;
            end else if (cnt_q == CNT_LAST) begin
               tt_d    = 3'b010;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_CAPTURE: state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         S_TRAP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      opcode = 6'b000000;
      if (store_q) begin
         unique case (size_q)
            2'b00:   opcode = 6'b000101;
            2'b01:   opcode = 6'b000110;
            default: opcode = 6'b000100;
         endcase
      end else begin
         unique case (size_q)
            2'b00:   opcode = {2'b00, sgn_q, 3'b001};
            2'b01:   opcode = {2'b00, sgn_q, 3'b010};
            default: opcode = 6'b000000;
         endcase
      end
   end

   always_comb begin
      bus.MAR_Enable     = 1'b0;
      bus.MDR_Enable     = 1'b0;
      bus.MDR_Mux_select = 1'b0;
      bus.TEMP_Enable    = 1'b0;
      bus.RAM_enable     = 1'b0;
      bus.RAM_OpCode     = 6'b000000;
      bus.done           = 1'b0;
      bus.trap           = 1'b0;
      bus.busy           = (state_q != S_IDLE);
      bus.trap_tt        = tt_q;
      unique case (state_q)
         S_ADDR:  bus.MAR_Enable = 1'b1;
         S_WDATA: bus.MDR_Enable = 1'b1;
         S_ACCESS: begin
            bus.RAM_enable = 1'b1;
            bus.RAM_OpCode = opcode;
         end
         S_CAPTURE: begin
            bus.RAM_enable     = 1'b1;
            bus.RAM_OpCode     = opcode;
            bus.MDR_Enable     = 1'b1;
            bus.MDR_Mux_select = 1'b1;
            bus.TEMP_Enable    = 1'b1;
         end
         S_DONE:  bus.done = 1'b1;
         S_TRAP:  bus.trap = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table plus scoreboard queue,
// with hand sequences for busy-req and mid-access reset.
module tb_mem_access_ctrl;

   typedef struct {
      logic       st;
      logic [1:0] sz;
      logic       sg;
      logic [1:0] lsb;
      int         wt;
      logic       is_trap;
      logic [2:0] tt;
      logic [5:0] op;
      int         lat;
      int         ram;
      int         wd;
      int         cap;
   } vec_t;

   logic Clk = 1'b0;
   logic Clr;
   int   n_checks = 0;
   int   n_fail = 0;
   vec_t q[$];
   vec_t tbl[13];
   int   cyc = 0;
   int   ram = 0;
   int   acc = 0;
   int   wd = 0;
   int   cap = 0;
   logic [2:0] last_tt = 3'b000;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(.TIMEOUT(4)) dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus.slave)
   );

   always #5 Clk = ~Clk;

   task automatic check(string nm, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(logic st, logic [1:0] sz, logic sg,
                               logic [1:0] lsb, int wt, logic is_trap,
                               logic [2:0] tt, logic [5:0] op, int lat,
                               int ram_c);
      vec_t v;
      v.st = st; v.sz = sz; v.sg = sg; v.lsb = lsb; v.wt = wt;
      v.is_trap = is_trap; v.tt = tt; v.op = op; v.lat = lat;
      v.ram = ram_c;
      v.wd  = (st && !is_trap) ? 1 : 0;
      v.cap = (!st && !is_trap) ? 1 : 0;
      if (is_trap && tt == 3'b010 && st) v.wd = 1;
      return v;
   endfunction

   // RAM model and output monitor, sampled on the falling edge
   always @(negedge Clk) begin
      if (!Clr) begin
         cyc = 0; ram = 0; acc = 0; wd = 0; cap = 0;
         bus.MFC = 1'b0;
      end else begin
         if (bus.busy) cyc++;
         if (bus.RAM_enable) begin
            ram++;
            if (q.size() != 0) check("opcode", int'(bus.RAM_OpCode), int'(q[0].op));
         end
         if (bus.MDR_Enable && !bus.MDR_Mux_select) wd++;
         if (bus.MDR_Enable && bus.MDR_Mux_select && bus.TEMP_Enable) cap++;
         if (bus.RAM_enable && !bus.MDR_Enable) begin
            bus.MFC = (q.size() != 0) && (acc == q[0].wt);
            acc++;
         end else begin
            bus.MFC = 1'b0;
         end
         if (bus.done || bus.trap) begin
            if (q.size() == 0) begin
               check("unexpected_end", 1, 0);
            end else begin
               vec_t e;
               e = q.pop_front();
               check("trap_vs_done", int'(bus.trap), int'(e.is_trap));
               check("end_single", int'(bus.trap & bus.done), 0);
               check("trap_tt", int'(bus.trap_tt), int'(e.tt));
               check("latency", cyc, e.lat);
               check("ram_cycles", ram, e.ram);
               check("wdata_cycles", wd, e.wd);
               check("capture_cycles", cap, e.cap);
               last_tt = e.tt;
            end
            cyc = 0; ram = 0; acc = 0; wd = 0; cap = 0;
         end
      end
   end

   task automatic wait_drain(string nm);
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(posedge Clk);
         n++;
      end
      if (q.size() != 0) begin
         check({nm, "_timeout"}, 0, 1);
         q.delete();
      end
      @(posedge Clk);
   endtask

   task automatic issue(vec_t v);
      @(posedge Clk); #1;
      check("idle_before_req", int'(bus.busy), 0);
      check("tt_held", int'(bus.trap_tt), int'(last_tt));
      q.push_back(v);
      bus.req        = 1'b1;
      bus.req_store  = v.st;
      bus.req_size   = v.sz;
      bus.req_signed = v.sg;
      bus.addr_lsb   = v.lsb;
      @(posedge Clk); #1;
      bus.req = 1'b0;
      check("mar_cycle1", int'(bus.MAR_Enable), 1);
   endtask

   initial begin
      vec_t v;
      int   n;
      Clr = 1'b0;
      bus.req = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.addr_lsb = 2'b00;

      tbl[0]  = mk(0, 2'b10, 0, 2'b00, 0,   0, 3'd0, 6'b000000, 4, 2);
      tbl[1]  = mk(1, 2'b00, 1, 2'b11, 3,   0, 3'd0, 6'b000101, 7, 4);
      tbl[2]  = mk(0, 2'b01, 0, 2'b01, 0,   1, 3'd1, 6'b000000, 2, 0);
      tbl[3]  = mk(0, 2'b01, 1, 2'b10, 0,   0, 3'd0, 6'b001010, 4, 2);
      tbl[4]  = mk(0, 2'b10, 0, 2'b00, 255, 1, 3'd2, 6'b000000, 6, 4);
      tbl[5]  = mk(0, 2'b10, 0, 2'b00, 3,   0, 3'd0, 6'b000000, 7, 5);
      tbl[6]  = mk(0, 2'b11, 0, 2'b00, 0,   1, 3'd3, 6'b000000, 2, 0);
      tbl[7]  = mk(0, 2'b00, 0, 2'b11, 1,   0, 3'd0, 6'b000001, 5, 3);
      tbl[8]  = mk(1, 2'b01, 0, 2'b10, 0,   0, 3'd0, 6'b000110, 4, 1);
      tbl[9]  = mk(1, 2'b10, 0, 2'b10, 0,   1, 3'd1, 6'b000100, 2, 0);
      tbl[10] = mk(0, 2'b00, 1, 2'b01, 0,   0, 3'd0, 6'b001001, 4, 2);
      tbl[11] = mk(1, 2'b10, 0, 2'b00, 255, 1, 3'd2, 6'b000100, 7, 4);
      tbl[12] = mk(0, 2'b10, 1, 2'b00, 0,   0, 3'd0, 6'b000000, 4, 2);

      repeat (2) @(posedge Clk);
      #1;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_ram", int'(bus.RAM_enable), 0);
      check("rst_opcode", int'(bus.RAM_OpCode), 0);
      check("rst_tt", int'(bus.trap_tt), 0);
      check("rst_strobes", int'({bus.MAR_Enable, bus.MDR_Enable,
            bus.MDR_Mux_select, bus.TEMP_Enable, bus.done, bus.trap}), 0);
      Clr = 1'b1;

      for (int i = 0; i < 13; i++) begin
         issue(tbl[i]);
         wait_drain($sformatf("vec%0d", i));
      end

      // req pulsed while busy must be ignored
      issue(tbl[5]);
      @(posedge Clk); #1;
      bus.req = 1'b1; bus.req_size = 2'b11;
      @(posedge Clk); #1;
      bus.req = 1'b0;
      wait_drain("busy_req");
      repeat (6) @(posedge Clk);
      #1;
      check("busy_req_idle", int'(bus.busy), 0);

      // reset in the middle of a stalled access
      issue(tbl[4]);
      n = 0;
      while (!bus.RAM_enable && n < 20) begin
         @(posedge Clk); #1;
         n++;
      end
      check("reached_access", int'(bus.RAM_enable), 1);
      #2;
      Clr = 1'b0;
      #1;
      check("mid_rst_ram", int'(bus.RAM_enable), 0);
      check("mid_rst_busy", int'(bus.busy), 0);
      check("mid_rst_outs", int'({bus.MAR_Enable, bus.MDR_Enable,
            bus.TEMP_Enable, bus.RAM_OpCode, bus.done, bus.trap,
            bus.trap_tt}), 0);
      q.delete();
      last_tt = 3'b000;
      @(posedge Clk); #1;
      Clr = 1'b1;
      issue(tbl[3]);
      wait_drain("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
